serial_deserializer: RTL
========================

Name: serial_deserializer

Overview:
Receive-side counterpart of the team's shift register. Collects a serial bit stream, one bit per qualified clock, into DATASIZE-bit words, MSB-first or LSB-first. Presents each completed word on a registered output with a valid/ready handshake. Sits on the far end of a serial link whose transmitter is a shift register driving ser_in_msb/ser_in_lsb.

Parameters:
DATASIZE, 8, word width in bits; legal range 2..64.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-low reset.
ser_valid_i  in  1  ser_data_i carries a bit this cycle.
ser_data_i  in  1  serial data bit.
ser_first_i  in  1  marks the first bit of a word; only meaningful when ser_valid_i=1.
msb_first_i  in  1  1 = stream is MSB-first, 0 = LSB-first; sampled with the first bit.
data_o  out  DATASIZE  completed word (output buffer).
data_valid_o  out  1  data_o holds an unconsumed word.
data_ready_i  in  1  consumer accepts data_o when data_valid_o=1.
overrun_o  out  1  one-cycle pulse: a completed word was dropped.
framing_err_o  out  1  one-cycle pulse: a word was aborted by an early ser_first_i.

Behaviour:
- Reset (rst_i=0, asynchronous) clears:
  - all outputs: data_o=0, data_valid_o=0, overrun_o=0, framing_err_o=0;
  - internal state: FSM=IDLE, bit counter=0, shift register=0.
- FSM has two states.
  - IDLE: ignores bits unless ser_valid_i=1 and ser_first_i=1. On that bit it:
    - latches msb_first_i into the order register;
    - shifts the bit in;
    - sets count=1;
    - goes to RECV.
  - RECV: each ser_valid_i=1 with ser_first_i=0 shifts one bit in and increments count. Cycles with ser_valid_i=0 are holes: no state change.
- Shift rule:
  - MSB-first: sh <= {sh[DATASIZE-2:0], bit}.
  - LSB-first: sh <= {bit, sh[DATASIZE-1:1]}.
- Word completion:
  - When the bit that makes count=DATASIZE is shifted in, the word is complete on that same edge.
  - The assembled value goes to the output buffer if the buffer is free or being consumed this cycle.
  - FSM returns to IDLE and count resets to 0.
  - Latency: data_valid_o=1 after the edge that samples the last bit (0 extra cycles).
- Output buffer:
  - data_valid_o clears on data_valid_o & data_ready_i, unless a new word loads on the same edge; in that case it stays 1 and data_o takes the new word.
  - data_o is stable while data_valid_o=1 and data_ready_i=0.
- Overrun:
  - Condition: word completes while data_valid_o=1 and data_ready_i=0.
  - Action: the new word is discarded, the buffer keeps the old word, overrun_o=1 for one cycle.
- Early first:
  - Condition: ser_valid_i=1 and ser_first_i=1 while in RECV (count 1..DATASIZE-1).
  - Action: the partial word is discarded and framing_err_o=1 for one cycle.
  - That bit starts a new word: count=1, order re-latched, FSM stays in RECV.
- ser_first_i with ser_valid_i=0 is ignored.
- msb_first_i is ignored except on first bits.
- Counter width is $clog2(DATASIZE+1). Count never exceeds DATASIZE.
- Reset mid-word: the partial word and the buffered word are both lost; the next word needs ser_first_i.
- overrun_o and framing_err_o are never asserted in the same cycle; an early first cannot complete a word.

Decomposition:
- Shared package deserializer_pkg holds:
  - typedef enum logic {ORDER_LSB_FIRST=0, ORDER_MSB_FIRST=1} order_t;
  - typedef enum logic {ST_IDLE, ST_RECV} deser_state_t.
- One sub-module: deser_out_buffer. It is the one-entry valid/ready register with a load/accept/overrun decision.
- FSM, counter and shift register stay in the top module.
- Assertions live in a separate serial_deserializer_assertions module bound to the DUV by a wrapper.

Test Plan:
1. MSB-first word, DATASIZE=8, data_ready_i=1, msb_first_i=1:
   - Stimulus: bits 1,0,1,0,0,1,0,1 on consecutive cycles, first on bit 0.
   - Response: data_o=0xA5 and data_valid_o=1 right after the 8th edge; valid drops the next cycle.
2. LSB-first word, msb_first_i=0:
   - Stimulus: stream 0,0,0,0,0,0,0,1.
   - Response: data_o=0x80.
   - Same stream MSB-first gives data_o=0x01.
3. Holes and backpressure:
   - Stimulus: word 0x3C with ser_valid_i low every other cycle, data_ready_i=0; then a second word 0xFF.
   - Response: data_o stays 0x3C and data_valid_o stays 1; overrun_o pulses once on the 8th bit of 0xFF. Then data_ready_i=1 gives one handshake and data_valid_o=0.
4. Simultaneous completion and accept:
   - Stimulus: buffer holds 0x11; word 0x22 completes on the same edge where data_ready_i=1.
   - Response: data_o=0x22, data_valid_o stays 1, overrun_o=0.
5. Early first:
   - Stimulus: 5 bits of a word, then ser_first_i=1, then 8 bits forming 0x5A.
   - Response: framing_err_o pulses one cycle on the restart bit; data_o=0x5A after the new 8th bit; no overrun_o.
6. Reset mid-word:
   - Stimulus: rst_i=0 asynchronously after 4 bits with a word buffered.
   - Response: data_valid_o=0 and data_o=0 immediately. After release, bits without ser_first_i are ignored; a full framed word 0xC3 is received correctly.

Source files
------------

// File: rtl/deserializer_pkg.sv
// Shared types for the serial deserializer: bit order and FSM state encodings.
package deserializer_pkg;

    typedef enum logic {
        ORDER_LSB_FIRST = 1'b0,
        ORDER_MSB_FIRST = 1'b1
    } order_t;

    typedef enum logic {
        ST_IDLE,
        ST_RECV
    } deser_state_t;

endpackage

// File: rtl/deser_out_buffer.sv
// One-entry valid/ready output register; decides load, accept and overrun on each edge.
module deser_out_buffer #(
    parameter int DATASIZE = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_req,
    input  logic [DATASIZE-1:0] load_data,
    input  logic                data_ready_i,
    output logic [DATASIZE-1:0] data_o,
    output logic                data_valid_o,
    output logic                overrun_o
);

    logic buf_free;

    // A word may load into an empty buffer or one being drained on this same edge.
    assign buf_free = !data_valid_o || data_ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_o       <= '0;
            data_valid_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            overrun_o <= load_req && !buf_free;
            if (load_req && buf_free) begin
                data_o       <= load_data;
                data_valid_o <= 1'b1;
            end else if (data_valid_o && data_ready_i) begin
                data_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_deserializer_assertions.sv
// Invariants of the deserializer: error pulses are exclusive and the bit count stays in range.
module serial_deserializer_assertions #(
    parameter int DATASIZE = 8
) (
    input logic                           clk,
    input logic                           rst_n,
    input logic [$clog2(DATASIZE+1)-1:0]  cnt,
    input logic                           overrun_o,
    input logic                           framing_err_o
);

    localparam int CW = $clog2(DATASIZE + 1);

    a_pulses_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(overrun_o && framing_err_o));

    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        cnt <= CW'(DATASIZE));

endmodule

// File: rtl/serial_deserializer_bind.sv
// Attaches the invariant checker to every serial_deserializer instance.
bind serial_deserializer serial_deserializer_assertions #(.DATASIZE(DATASIZE)) u_assertions (
    .clk           (clk_i),
    .rst_n         (rst_i),
    .cnt           (cnt),
    .overrun_o     (overrun_o),
    .framing_err_o (framing_err_o)
);

// File: rtl/serial_deserializer.sv
// Collects a framed serial bit stream into DATASIZE-bit words, MSB- or LSB-first,
// and hands completed words to a one-entry valid/ready output buffer.
module serial_deserializer
    import deserializer_pkg::*;
#(
    parameter int DATASIZE = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ser_valid_i,
    input  logic                ser_data_i,
    input  logic                ser_first_i,
    input  logic                msb_first_i,
    output logic [DATASIZE-1:0] data_o,
    output logic                data_valid_o,
    input  logic                data_ready_i,
    output logic                overrun_o,
    output logic                framing_err_o
);

    localparam int CW = $clog2(DATASIZE + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATASIZE - 1);

    deser_state_t        state, state_nx;
    order_t              order, order_nx, order_use;
    logic [CW-1:0]       cnt, cnt_nx;
    logic [DATASIZE-1:0] sh, sh_nx, sh_shifted;
    logic                first_bit, word_done, early_first;

    assign first_bit = ser_valid_i && ser_first_i;

    // The order on a first bit comes straight from the input so that bit shifts correctly.
    assign order_use  = first_bit ? order_t'(msb_first_i) : order;
    assign sh_shifted = (order_use == ORDER_MSB_FIRST) ? {sh[DATASIZE-2:0], ser_data_i}
                                                       : {ser_data_i, sh[DATASIZE-1:1]};

    always_comb begin
        state_nx    = state;
        order_nx    = order;
        cnt_nx      = cnt;
        sh_nx       = sh;
        word_done   = 1'b0;
        early_first = 1'b0;
        case (state)
            ST_IDLE: begin
                if (first_bit) begin
                    order_nx = order_use;
                    sh_nx    = sh_shifted;
                    cnt_nx   = CW'(1);
                    state_nx = ST_RECV;
                end
            end
            ST_RECV: begin
                if (first_bit) begin
                    early_first = 1'b1;
                    order_nx    = order_use;
                    sh_nx       = sh_shifted;
                    cnt_nx      = CW'(1);
                end else if (ser_valid_i) begin
                    sh_nx = sh_shifted;
                    if (cnt == LAST_CNT) begin
                        word_done = 1'b1;
                        cnt_nx    = '0;
                        state_nx  = ST_IDLE;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state         <= ST_IDLE;
            order         <= ORDER_LSB_FIRST;
            cnt           <= '0;
            sh            <= '0;
            framing_err_o <= 1'b0;
        end else begin
            state         <= state_nx;
            order         <= order_nx;
            cnt           <= cnt_nx;
            sh            <= sh_nx;
            framing_err_o <= early_first;
        end
    end

    deser_out_buffer #(.DATASIZE(DATASIZE)) u_out_buffer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_req     (word_done),
        .load_data    (sh_nx),
        .data_ready_i (data_ready_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .overrun_o    (overrun_o)
    );

endmodule
